// File: rtl/pe_pkg.sv
// Shared types and the saturating adder for the weight-stationary PE.
package pe_pkg;

  typedef enum logic {
    PE_MODE_SYSTOLIC = 1'b0,
    PE_MODE_ACC      = 1'b1
  } pe_mode_t;

  localparam int PE_PIPE_LAT = 2;
  // Operands are widened to this before adding, so PSUM_WIDTH must stay below it.
  localparam int PE_MAX_W = 128;

  typedef struct packed {
    logic                ovf;
    logic [PE_MAX_W-1:0] sum;
  } pe_add_t;

  // a and b arrive already sign/zero-extended from w bits, so the exact sum fits.
  function automatic pe_add_t pe_sat_add(input logic [PE_MAX_W-1:0] a,
                                         input logic [PE_MAX_W-1:0] b,
                                         input int unsigned         w,
                                         input logic                is_signed,
                                         input logic                sat_en);
    logic [PE_MAX_W-1:0] s;
    logic [PE_MAX_W-1:0] hi;
    logic [PE_MAX_W-1:0] lo;
    pe_add_t             r;
    s     = a + b;
    r.sum = s;
    r.ovf = 1'b0;
    hi    = '0;
    lo    = '0;
    if (sat_en) begin
      if (is_signed) begin
        hi = (PE_MAX_W'(1) << (w - 1)) - PE_MAX_W'(1);
        lo = ~hi;
        if ($signed(s) > $signed(hi)) begin
          r.sum = hi;
          r.ovf = 1'b1;
        end else if ($signed(s) < $signed(lo)) begin
          r.sum = lo;
          r.ovf = 1'b1;
        end
      end else begin
        hi = (PE_MAX_W'(1) << w) - PE_MAX_W'(1);
        if (s > hi) begin
          r.sum = hi;
          r.ovf = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// Stage 1 of the PE: signed/unsigned multiply plus capture of psum and beat controls.
module pe_mul_stage
  import pe_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            clear_i,
  input  logic            vld_i,
  input  logic            signed_i,
  input  logic            acc_mode_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   w_i,
  input  logic [PW-1:0]   psum_i,
  output logic            vld_o,
  output logic            signed_o,
  output pe_mode_t        mode_o,
  output logic [2*DW-1:0] prod_o,
  output logic [PW-1:0]   psum_o
);

  logic signed [DW:0]     a_x;
  logic signed [DW:0]     w_x;
  logic signed [2*DW+1:0] prod_full;
  logic [2*DW-1:0]        prod_d;
  logic                   unused_prod_hi;

  logic            vld_q;
  logic            signed_q;
  pe_mode_t        mode_q;
  logic [2*DW-1:0] prod_q;
  logic [PW-1:0]   psum_q;

  // One extra bit lets a single signed multiplier serve both operand modes.
  always_comb begin
    a_x       = {signed_i & a_i[DW-1], a_i};
    w_x       = {signed_i & w_i[DW-1], w_i};
    prod_full = a_x * w_x;
    prod_d    = prod_full[2*DW-1:0];
  end

  assign unused_prod_hi = ^prod_full[2*DW+1:2*DW];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vld_q    <= 1'b0;
      signed_q <= 1'b0;
      mode_q   <= PE_MODE_SYSTOLIC;
      prod_q   <= '0;
      psum_q   <= '0;
    end else begin
      vld_q <= clear_i ? 1'b0 : vld_i;
      if (vld_i) begin
        prod_q   <= prod_d;
        psum_q   <= psum_i;
        signed_q <= signed_i;
        mode_q   <= pe_mode_t'(acc_mode_i);
      end
    end
  end

  assign vld_o    = vld_q;
  assign signed_o = signed_q;
  assign mode_o   = mode_q;
  assign prod_o   = prod_q;
  assign psum_o   = psum_q;

endmodule

// File: rtl/pe_ws_pipe.sv
// Weight-stationary MAC PE with double-buffered weight and a two-stage multiply/add pipe.
module pe_ws_pipe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH_IN = 8,
  parameter int PSUM_WIDTH    = 32,
  parameter bit SAT_EN        = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     signed_i,
  input  logic                     acc_mode_i,
  input  logic                     weight_vld_i,
  input  logic [DATA_WIDTH_IN-1:0] weight_i,
  input  logic                     weight_swap_i,
  output logic [DATA_WIDTH_IN-1:0] weight_o,
  output logic                     weight_vld_o,
  input  logic                     active_vld_i,
  input  logic [DATA_WIDTH_IN-1:0] active_i,
  output logic [DATA_WIDTH_IN-1:0] active_o,
  output logic                     active_vld_o,
  input  logic [PSUM_WIDTH-1:0]    psum_i,
  output logic [PSUM_WIDTH-1:0]    psum_o,
  output logic                     psum_vld_o,
  output logic                     sat_o
);

  localparam int PW = 2 * DATA_WIDTH_IN;

  logic [DATA_WIDTH_IN-1:0] shadow_q, active_w_q, act_q;
  logic                     wvld_q, act_vld_q;
  logic [PSUM_WIDTH-1:0]    psum_q, psum_d;
  logic                     psum_vld_q, sat_q, sat_d;

  logic                  vld1, signed1;
  pe_mode_t              mode1;
  logic [PW-1:0]         prod1;
  logic [PSUM_WIDTH-1:0] psum1;
  logic [PSUM_WIDTH-1:0] prod_x, base;
  pe_add_t               add_r;
  logic                  unused_sum_hi;

  function automatic logic [PE_MAX_W-1:0] widen(input logic [PSUM_WIDTH-1:0] v,
                                                input logic                  s);
    return {{(PE_MAX_W-PSUM_WIDTH){s & v[PSUM_WIDTH-1]}}, v};
  endfunction

  pe_mul_stage #(.DW(DATA_WIDTH_IN), .PW(PSUM_WIDTH)) u_mul (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clear_i    (clear_i),
    .vld_i      (active_vld_i),
    .signed_i   (signed_i),
    .acc_mode_i (acc_mode_i),
    .a_i        (active_i),
    .w_i        (active_w_q),
    .psum_i     (psum_i),
    .vld_o      (vld1),
    .signed_o   (signed1),
    .mode_o     (mode1),
    .prod_o     (prod1),
    .psum_o     (psum1)
  );

  always_comb begin
    prod_x = {{(PSUM_WIDTH-PW){signed1 & prod1[PW-1]}}, prod1};
    base   = (mode1 == PE_MODE_ACC) ? psum_q : psum1;
    add_r  = pe_sat_add(widen(base, signed1), widen(prod_x, signed1),
                        PSUM_WIDTH, signed1, SAT_EN);
    psum_d = vld1 ? add_r.sum[PSUM_WIDTH-1:0] : psum_q;
    sat_d  = sat_q | (vld1 & add_r.ovf);
  end

  assign unused_sum_hi = ^add_r.sum[PE_MAX_W-1:PSUM_WIDTH];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      shadow_q   <= '0;
      active_w_q <= '0;
      wvld_q     <= 1'b0;
      act_q      <= '0;
      act_vld_q  <= 1'b0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      if (weight_vld_i)  shadow_q   <= weight_i;
      if (weight_swap_i) active_w_q <= shadow_q;
      wvld_q    <= weight_vld_i;
      act_q     <= active_i;
      act_vld_q <= active_vld_i;
      if (clear_i) begin
        psum_q     <= '0;
        psum_vld_q <= 1'b0;
        sat_q      <= 1'b0;
      end else begin
        psum_q     <= psum_d;
        psum_vld_q <= vld1;
        sat_q      <= sat_d;
      end
    end
  end

  assign weight_o     = shadow_q;
  assign weight_vld_o = wvld_q;
  assign active_o     = act_q;
  assign active_vld_o = act_vld_q;
  assign psum_o       = psum_q;
  assign psum_vld_o   = psum_vld_q;
  assign sat_o        = sat_q;

endmodule

// File: tb/tb_pe_ws_pipe.sv
// Scoreboard bench: a saturating PE, a wrapping twin on the same inputs, and a chained PE.
module tb_pe_ws_pipe;
  import pe_pkg::*;

  localparam int DW = 8;
  localparam int PW = 32;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rstn, clear, sgn, accm, wvld, swap, avld;
  logic [DW-1:0] wt, act;
  logic [PW-1:0] psi;

  logic [DW-1:0] u0_wo, u0_ao;
  logic          u0_wvo, u0_avo, u0_pvld, u0_sat;
  logic [PW-1:0] u0_psum;

  logic [PW-1:0] uw_psum;
  logic          uw_pvld, uw_sat;
  logic [DW-1:0] uw_unused_wo, uw_unused_ao;
  logic          uw_unused_wvo, uw_unused_avo;

  logic [DW-1:0] u1_wo, u1_unused_ao;
  logic          u1_unused_wvo, u1_unused_avo, u1_unused_pvld, u1_unused_sat;
  logic [PW-1:0] u1_unused_psum;

  pe_ws_pipe #(.DATA_WIDTH_IN(DW), .PSUM_WIDTH(PW), .SAT_EN(1'b1)) u0 (
    .clk_i(clk_i), .rstn_i(rstn), .clear_i(clear), .signed_i(sgn), .acc_mode_i(accm),
    .weight_vld_i(wvld), .weight_i(wt), .weight_swap_i(swap), .weight_o(u0_wo),
    .weight_vld_o(u0_wvo), .active_vld_i(avld), .active_i(act), .active_o(u0_ao),
    .active_vld_o(u0_avo), .psum_i(psi), .psum_o(u0_psum), .psum_vld_o(u0_pvld),
    .sat_o(u0_sat));

  pe_ws_pipe #(.DATA_WIDTH_IN(DW), .PSUM_WIDTH(PW), .SAT_EN(1'b0)) uw (
    .clk_i(clk_i), .rstn_i(rstn), .clear_i(clear), .signed_i(sgn), .acc_mode_i(accm),
    .weight_vld_i(wvld), .weight_i(wt), .weight_swap_i(swap), .weight_o(uw_unused_wo),
    .weight_vld_o(uw_unused_wvo), .active_vld_i(avld), .active_i(act),
    .active_o(uw_unused_ao), .active_vld_o(uw_unused_avo), .psum_i(psi),
    .psum_o(uw_psum), .psum_vld_o(uw_pvld), .sat_o(uw_sat));

  pe_ws_pipe #(.DATA_WIDTH_IN(DW), .PSUM_WIDTH(PW), .SAT_EN(1'b1)) u1 (
    .clk_i(clk_i), .rstn_i(rstn), .clear_i(clear), .signed_i(sgn), .acc_mode_i(accm),
    .weight_vld_i(u0_wvo), .weight_i(u0_wo), .weight_swap_i(1'b0), .weight_o(u1_wo),
    .weight_vld_o(u1_unused_wvo), .active_vld_i(u0_avo), .active_i(u0_ao),
    .active_o(u1_unused_ao), .active_vld_o(u1_unused_avo), .psum_i(u0_psum),
    .psum_o(u1_unused_psum), .psum_vld_o(u1_unused_pvld), .sat_o(u1_unused_sat));

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [PW-1:0] ps;
    logic          sat;
    logic [PW-1:0] pw;
    int            e;
  } exp_t;
  exp_t sb[$];

  // Reference state: the two weight buffers, both accumulators and the sticky flag.
  logic [DW-1:0] sh_m, aw_m;
  logic [PW-1:0] acc_s, acc_w;
  logic          sat_m;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic longint to_l(input logic [PW-1:0] x, input logic s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  task automatic model_beat(input logic [DW-1:0] a, input logic [PW-1:0] ps,
                            input logic sg, input logic md);
    longint pp, ss, sw;
    exp_t   it;
    if (sg) pp = longint'($signed(a)) * longint'($signed(aw_m));
    else    pp = longint'(a) * longint'(aw_m);
    ss = to_l(md ? acc_s : ps, sg) + pp;
    sw = to_l(md ? acc_w : ps, sg) + pp;
    if (sg && ss > 64'sd2147483647) begin
      ss = 64'sd2147483647; sat_m = 1'b1;
    end else if (sg && ss < -64'sd2147483648) begin
      ss = -64'sd2147483648; sat_m = 1'b1;
    end else if (!sg && ss > 64'sd4294967295) begin
      ss = 64'sd4294967295; sat_m = 1'b1;
    end
    acc_s  = ss[31:0];
    acc_w  = sw[31:0];
    it.ps  = acc_s;
    it.sat = sat_m;
    it.pw  = acc_w;
    it.e   = edge_cnt;
    sb.push_back(it);
  endtask

  task automatic tick(input logic wv, input logic [DW-1:0] w, input logic sw,
                      input logic av, input logic [DW-1:0] a, input logic [PW-1:0] ps,
                      input logic sg, input logic md, input logic clr);
    wvld = wv; wt = w; swap = sw; avld = av; act = a; psi = ps;
    sgn = sg; accm = md; clear = clr;
    if (clr) begin
      acc_s = '0; acc_w = '0; sat_m = 1'b0;
    end
    if (av) model_beat(a, ps, sg, md);
    if (sw) aw_m = sh_m;
    if (wv) sh_m = w;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, DW'($urandom), 1'b0, 1'b0, DW'($urandom), $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [DW-1:0] a, input logic [PW-1:0] ps,
                      input logic sg, input logic md);
    tick(1'b0, 8'h00, 1'b0, 1'b1, a, ps, sg, md, 1'b0);
  endtask

  task automatic load_swap(input logic [DW-1:0] w);
    tick(1'b1, w, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk_i) begin
    exp_t it;
    if (u0_pvld) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_psum_vld actual=1 expected=0");
      end else begin
        it = sb.pop_front();
        check("psum_sat", u0_psum, it.ps);
        check("sat_flag", 32'(u0_sat), 32'(it.sat));
        check("psum_wrap", uw_psum, it.pw);
        check("wrap_sat_flag", 32'(uw_sat), 32'h0);
        check("wrap_vld", 32'(uw_pvld), 32'h1);
        check("latency", 32'(edge_cnt - it.e), 32'(PE_PIPE_LAT));
      end
    end
  end

  initial begin
    sh_m = '0; aw_m = '0; acc_s = '0; acc_w = '0; sat_m = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvld = 1'($urandom); wt = DW'($urandom); swap = 1'($urandom);
      avld = 1'($urandom); act = DW'($urandom); psi = $urandom;
      sgn = 1'($urandom); accm = 1'($urandom); clear = 1'($urandom);
      @(posedge clk_i);
      #1;
    end
    check("rst_psum", u0_psum, 32'h0);
    check("rst_psum_vld", 32'(u0_pvld), 32'h0);
    check("rst_sat", 32'(u0_sat), 32'h0);
    check("rst_weight_o", 32'(u0_wo), 32'h0);
    check("rst_weight_vld_o", 32'(u0_wvo), 32'h0);
    check("rst_active_o", 32'(u0_ao), 32'h0);
    check("rst_active_vld_o", 32'(u0_avo), 32'h0);
    rstn = 1'b1;
    idle(3);
    check("post_rst_psum_vld", 32'(u0_pvld), 32'h0);

    // Basic unsigned systolic beat.
    load_swap(8'd3);
    beat(8'd5, 32'd100, 1'b0, 1'b0);
    check("active_o_fwd", 32'(u0_ao), 32'd5);
    check("active_vld_fwd", 32'(u0_avo), 32'h1);
    idle(3);
    check("basic_psum_held", u0_psum, 32'd115);

    // Same bit patterns, signed then unsigned.
    load_swap(8'hFE);
    beat(8'hFD, 32'd0, 1'b1, 1'b0);
    idle(3);
    check("signed_prod", u0_psum, 32'd6);
    beat(8'hFD, 32'd0, 1'b0, 1'b0);
    idle(3);
    check("unsigned_prod", u0_psum, 32'd64262);

    // Signed overflow: clamps in u0, wraps in uw.
    load_swap(8'd127);
    beat(8'd127, 32'h7FFFFFF0, 1'b1, 1'b0);
    idle(3);
    check("sat_clamp", u0_psum, 32'h7FFFFFFF);
    check("sat_set", 32'(u0_sat), 32'h1);
    check("wrap_value", uw_psum, 32'h80003EF1);
    check("wrap_no_sat", 32'(uw_sat), 32'h0);
    beat(8'd1, 32'd0, 1'b1, 1'b0);
    idle(3);
    check("sat_sticky", 32'(u0_sat), 32'h1);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    check("clear_psum", u0_psum, 32'h0);
    check("clear_sat", 32'(u0_sat), 32'h0);
    idle(1);

    // Swap hazard: the beat sampled with a swap uses the old active weight.
    load_swap(8'd2);
    tick(1'b1, 8'd7, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b1, 8'd4, 32'd0, 1'b0, 1'b0, 1'b0);
    beat(8'd4, 32'd0, 1'b0, 1'b0);
    tick(1'b1, 8'd9, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    check("swap_shadow_new", 32'(u0_wo), 32'd9);
    beat(8'd1, 32'd0, 1'b0, 1'b0);
    idle(3);
    check("swap_active_old_shadow", u0_psum, 32'd7);

    // Local accumulate, back-to-back beats.
    load_swap(8'd2);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) beat(DW'(i), $urandom, 1'b0, 1'b1);
    idle(3);
    check("acc_final", u0_psum, 32'd20);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    check("acc_clear", u0_psum, 32'h0);
    idle(1);

    // Weight daisy chain into the second PE.
    tick(1'b1, 8'd7, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'd9, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    check("chain_pe0_shadow", 32'(u0_wo), 32'd9);
    check("chain_pe1_shadow", 32'(u1_wo), 32'd7);
    idle(2);

    // Randomised traffic: weight loads, swaps, modes and large psums.
    for (int i = 0; i < 400; i++) begin
      logic [PW-1:0] ps;
      ps = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 60000));
      tick(($urandom_range(0, 9) < 3), DW'($urandom), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 6), DW'($urandom), ps,
           1'($urandom), 1'($urandom), 1'b0);
    end
    idle(4);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
